// File: rtl/clk_div_ctrl.sv
// Run-time controller for an I_CLK divider: programmable half-period O_CLK,
// free-run or burst mode, config changes applied only at period boundaries.
module clk_div_ctrl #(
    parameter int CNT_W    = 16,
    parameter int DEF_HALF = 20,
    parameter int BURST_W  = 8
) (
    input  logic               I_CLK,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               O_CLK,
    output logic               O_TICK,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   half_q, half_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   sh_half_q, sh_half_d;
    logic [BURST_W-1:0] sh_burst_q, sh_burst_d;
    logic               sh_full_q, sh_full_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [BURST_W-1:0] period_q, period_d;
    logic               stop_q, stop_d;
    logic               clk_q, clk_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;

    logic accept_s;
    logic legal_s;
    logic phase_last_s;
    logic last_period_s;

    assign accept_s      = cfg_valid & ready_q;
    assign legal_s       = accept_s & (cfg_half != {CNT_W{1'b0}});
    assign phase_last_s  = (phase_q == (half_q - CNT_W'(1)));
    assign last_period_s = (burst_q != {BURST_W{1'b0}}) &&
                           (period_q == (burst_q - BURST_W'(1)));

    // State and output registers.
    always_ff @(posedge I_CLK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            half_q     <= DEF_H;
            burst_q    <= {BURST_W{1'b0}};
            sh_half_q  <= {CNT_W{1'b0}};
            sh_burst_q <= {BURST_W{1'b0}};
            sh_full_q  <= 1'b0;
            phase_q    <= {CNT_W{1'b0}};
            period_q   <= {BURST_W{1'b0}};
            stop_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            burst_q    <= burst_d;
            sh_half_q  <= sh_half_d;
            sh_burst_q <= sh_burst_d;
            sh_full_q  <= sh_full_d;
            phase_q    <= phase_d;
            period_q   <= period_d;
            stop_q     <= stop_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        burst_d    = burst_q;
        sh_half_d  = sh_half_q;
        sh_burst_d = sh_burst_q;
        sh_full_d  = sh_full_q;
        phase_d    = phase_q;
        period_d   = period_q;
        stop_d     = stop_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = accept_s & (cfg_half == {CNT_W{1'b0}});

        case (state_q)
            ST_IDLE: begin
                clk_d    = 1'b0;
                phase_d  = {CNT_W{1'b0}};
                period_d = {BURST_W{1'b0}};
                stop_d   = 1'b0;
                if (legal_s) begin
                    half_d  = cfg_half;
                    burst_d = cfg_burst;
                end else begin
                    half_d  = half_q;
                    burst_d = burst_q;
                end
                if (start && !stop) begin
                    state_d = ST_RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    stop_d = 1'b1;
                end else begin
                    stop_d = stop_q;
                end
                if (legal_s) begin
                    sh_half_d  = cfg_half;
                    sh_burst_d = cfg_burst;
                    sh_full_d  = 1'b1;
                end else begin
                    sh_full_d  = sh_full_q;
                end

                if (!phase_last_s) begin
                    phase_d = phase_q + CNT_W'(1);
                end else if (clk_q) begin
                    phase_d = {CNT_W{1'b0}};
                    clk_d   = 1'b0;
                end else if (stop_q || stop || last_period_s) begin
                    // Run ends; any pending config is promoted so none is lost
                    // and IDLE always starts with an empty shadow slot.
                    phase_d   = {CNT_W{1'b0}};
                    period_d  = {BURST_W{1'b0}};
                    state_d   = ST_IDLE;
                    clk_d     = 1'b0;
                    stop_d    = 1'b0;
                    done_d    = 1'b1;
                    sh_full_d = 1'b0;
                    if (legal_s) begin
                        half_d  = cfg_half;
                        burst_d = cfg_burst;
                    end else if (sh_full_q) begin
                        half_d  = sh_half_q;
                        burst_d = sh_burst_q;
                    end else begin
                        half_d  = half_q;
                        burst_d = burst_q;
                    end
                end else begin
                    phase_d = {CNT_W{1'b0}};
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                    if (sh_full_q) begin
                        half_d    = sh_half_q;
                        burst_d   = sh_burst_q;
                        sh_full_d = 1'b0;
                        period_d  = {BURST_W{1'b0}};
                    end else if (burst_q != {BURST_W{1'b0}}) begin
                        period_d = period_q + BURST_W'(1);
                    end else begin
                        period_d = period_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                clk_d   = 1'b0;
            end
        endcase

        busy_d  = (state_d == ST_RUN);
        ready_d = ~sh_full_d;
    end

    assign O_CLK     = clk_q;
    assign O_TICK    = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = err_q;
    assign cfg_ready = ready_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: table of per-cycle vectors for the IDLE /
// burst path plus hand-written multi-cycle sequences for the run corners.
module tb_clk_div_ctrl;

    logic        I_CLK;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_half;
    logic [7:0]  cfg_burst;
    logic        start;
    logic        stop;
    logic        O_CLK;
    logic        O_TICK;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    clk_div_ctrl #(.CNT_W(16), .DEF_HALF(20), .BURST_W(8)) dut (
        .I_CLK     (I_CLK),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_half  (cfg_half),
        .cfg_burst (cfg_burst),
        .start     (start),
        .stop      (stop),
        .O_CLK     (O_CLK),
        .O_TICK    (O_TICK),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic        cv;
        logic [15:0] h;
        logic [7:0]  b;
        logic        st;
        logic        sp;
        logic [5:0]  exp;   // {O_CLK, O_TICK, busy, done, cfg_err, cfg_ready}
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick_clk();
        @(posedge I_CLK);
        #1;
    endtask

    // Expected O_CLK/O_TICK at cycle idx of a run with half-period h.
    task automatic chk_wave(input int h, input int idx, input string nm);
        int  p;
        logic [7:0] exp;
        p   = idx % (2 * h);
        exp = {6'b000000, (p < h), (p == 0)};
        check($sformatf("%s[%0d]", nm, idx), {6'b000000, O_CLK, O_TICK}, exp);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_half  = 16'd0;
        cfg_burst = 8'd0;
        start     = 1'b0;
        stop      = 1'b0;

        // Reset state
        tick_clk();
        check("reset_outputs", {2'b00, O_CLK, O_TICK, busy, done, cfg_err, cfg_ready}, 8'b00000001);
        rst = 1'b0;
        tick_clk();

        // Default divide-by-40 free run
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        chk_wave(20, 0, "def");
        for (int i = 1; i < 80; i++) begin
            tick_clk();
            chk_wave(20, i, "def");
        end
        check("def_busy", {7'd0, busy}, 8'd1);

        // Config H=5 mid-high-phase: old period completes first
        for (int i = 80; i < 85; i++) begin
            tick_clk();
            chk_wave(20, i, "pre_cfg");
        end
        cfg_valid = 1'b1;
        cfg_half  = 16'd5;
        cfg_burst = 8'd0;
        tick_clk();
        cfg_valid = 1'b0;
        chk_wave(20, 85, "pre_cfg");
        check("shadow_full_ready", {7'd0, cfg_ready}, 8'd0);
        for (int i = 86; i < 120; i++) begin
            tick_clk();
            chk_wave(20, i, "pre_cfg");
        end
        for (int j = 0; j < 22; j++) begin
            tick_clk();
            chk_wave(5, j, "h5");
            if (j == 0) check("shadow_applied_ready", {7'd0, cfg_ready}, 8'd1);
        end

        // Stop in high phase: period completes, then done
        stop = 1'b1;
        tick_clk();
        stop = 1'b0;
        chk_wave(5, 22, "h5_stop");
        for (int j = 23; j < 30; j++) begin
            tick_clk();
            chk_wave(5, j, "h5_stop");
        end
        tick_clk();
        check("stop_done", {5'd0, O_CLK, busy, done}, 8'b001);
        tick_clk();
        check("stop_after", {5'd0, O_CLK, busy, done}, 8'b000);
        tick_clk();
        check("stop_held", {5'd0, O_CLK, busy, done}, 8'b000);

        // Illegal config while running
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        chk_wave(5, 0, "err_run");
        cfg_valid = 1'b1;
        cfg_half  = 16'd0;
        tick_clk();
        cfg_valid = 1'b0;
        check("run_err_pulse", {6'd0, cfg_err, cfg_ready}, 8'b11);
        chk_wave(5, 1, "err_run");
        tick_clk();
        check("run_err_clear", {6'd0, cfg_err, cfg_ready}, 8'b01);
        chk_wave(5, 2, "err_run");
        for (int j = 3; j < 13; j++) begin
            tick_clk();
            chk_wave(5, j, "err_run");
        end

        // Async reset in high phase, then restart at default H
        #2 rst = 1'b1;
        #1;
        check("async_rst", {4'd0, O_CLK, busy, done, cfg_ready}, 8'b0001);
        #1 rst = 1'b0;
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        for (int i = 0; i < 42; i++) begin
            if (i != 0) tick_clk();
            chk_wave(20, i, "post_rst");
        end
        check("post_rst_busy", {7'd0, busy}, 8'd1);

        // Reset back to IDLE for the vector table
        rst = 1'b1;
        #2 rst = 1'b0;
        tick_clk();

        vecs[0]  = '{1'b1, 16'd2, 8'd3, 1'b0, 1'b0, 6'b000001};
        vecs[1]  = '{1'b1, 16'd0, 8'd7, 1'b0, 1'b0, 6'b000011};
        vecs[2]  = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b000001};
        vecs[3]  = '{1'b0, 16'd0, 8'd0, 1'b1, 1'b0, 6'b111001};
        vecs[4]  = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b101001};
        vecs[5]  = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b001001};
        vecs[6]  = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b001001};
        vecs[7]  = '{1'b0, 16'd0, 8'd0, 1'b1, 1'b0, 6'b111001};
        vecs[8]  = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b101001};
        vecs[9]  = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b001001};
        vecs[10] = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b001001};
        vecs[11] = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b111001};
        vecs[12] = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b101001};
        vecs[13] = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b001001};
        vecs[14] = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b001001};
        vecs[15] = '{1'b0, 16'd0, 8'd0, 1'b0, 1'b0, 6'b000101};
        vecs[16] = '{1'b0, 16'd0, 8'd0, 1'b1, 1'b1, 6'b000001};
        vecs[17] = '{1'b0, 16'd0, 8'd0, 1'b1, 1'b0, 6'b111001};

        for (int k = 0; k < 18; k++) begin
            cfg_valid = vecs[k].cv;
            cfg_half  = vecs[k].h;
            cfg_burst = vecs[k].b;
            start     = vecs[k].st;
            stop      = vecs[k].sp;
            tick_clk();
            check($sformatf("vec[%0d]", k),
                  {2'b00, O_CLK, O_TICK, busy, done, cfg_err, cfg_ready},
                  {2'b00, vecs[k].exp});
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
